pll_reconfig_ctrl: RTL and testbench
====================================

Name: pll_reconfig_ctrl

Overview:
Supervisor and dynamic-reconfiguration controller for the Gowin rPLL. It drives the rPLL's IDSEL/FBDSEL/ODSEL and RESET pins, and sequences reset, lock wait, stability qualification and retry. It holds the downstream system in reset until the PLL output is usable. The block sits beside the rPLL instance and is clocked from the raw 27 MHz board clock, never from the PLL output.

Parameters:
INIT_IDSEL, 6'd56, dynamic IDSEL code applied after reset (pre-encoded rPLL dynamic code, passed through unmodified).
INIT_FBDSEL, 6'd61, dynamic FBDSEL code applied after reset.
INIT_ODSEL, 6'd32, dynamic ODSEL code applied after reset.
RST_CYCLES, 16, pll_reset high time in clk cycles; must be >=1.
LOCK_TIMEOUT, 65535, clk cycles to wait for synchronised lock before counting a failed attempt.
STABLE_CYCLES, 1024, consecutive cycles synchronised lock must stay high before release.
MAX_RETRY, 3, failed attempts allowed before error; range 1..15.
CNT_W, 20, shared counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
clk  in  1  27 MHz input clock (same net as rPLL clkin)
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  new configuration request
req_ready  out  1  high when a request is accepted this cycle if req_valid
req_idsel  in  6  requested IDSEL code
req_fbdsel  in  6  requested FBDSEL code
req_odsel  in  6  requested ODSEL code
pll_lock  in  1  rPLL LOCK, asynchronous to clk
pll_reset  out  1  to rPLL RESET
pll_idsel  out  6  to rPLL IDSEL
pll_fbdsel  out  6  to rPLL FBDSEL
pll_odsel  out  6  to rPLL ODSEL
sys_rst_n  out  1  active-low reset for the PLL-clocked logic
locked  out  1  qualified lock status
error  out  1  sticky failure flag
retry_cnt  out  4  failed attempts for the current configuration

Behaviour:
- Reset values (async, while reset_n=0):
  - pll_reset=1, sel outputs=INIT_*, sys_rst_n=0, locked=0, error=0, retry_cnt=0, req_ready=0.
  - State=HOLD, counter=0, lock synchroniser=0.
- pll_lock passes through a 2-FF synchroniser (lock_s) before use; it never feeds logic directly.
- All outputs are registered. Sel outputs change only on entry to HOLD, and only while pll_reset=1.
- HOLD:
  - pll_reset=1, sys_rst_n=0, locked=0.
  - Counts RST_CYCLES cycles, then goes to WAIT_LOCK with counter cleared and pll_reset=0.
- WAIT_LOCK:
  - lock_s=1 -> STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> FAIL.
- STABLE:
  - lock_s=0 -> FAIL.
  - lock_s=1 for STABLE_CYCLES consecutive cycles -> RUN.
- RUN:
  - locked=1, sys_rst_n=1, retry_cnt cleared to 0, req_ready=1.
  - lock_s falling in RUN: next cycle locked=0 and sys_rst_n=0, then -> HOLD with the same codes. Loss of lock is not counted as a retry.
- FAIL:
  - retry_cnt increments.
  - If new retry_cnt < MAX_RETRY -> HOLD with the same codes.
  - Otherwise -> ERROR.
- ERROR:
  - error=1 (sticky until reset_n or an accepted request), pll_reset=1, sys_rst_n=0, req_ready=1.
- Request handshake:
  - Accept when req_valid & req_ready (RUN or ERROR only).
  - On accept, latch the req_* codes into the sel outputs, clear error and retry_cnt, assert sys_rst_n=0 and locked=0 in the same edge, and go to HOLD.
  - req_valid outside RUN/ERROR is ignored (not queued); the requester must hold it.
- Simultaneous events:
  - Request accepted in the same cycle lock_s falls in RUN: the request wins (HOLD with new codes).
- reset_n asserted mid-sequence:
  - Immediate return to reset values. INIT_* codes are restored and any requested configuration is lost.
- Timing:
  - sys_rst_n deassertion latency after pll_lock rises = 2 (sync) + 1 (WAIT_LOCK->STABLE) + STABLE_CYCLES + 1 cycles.

Test Plan:
Test parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
1. Release reset_n; pll_lock rises 10 cycles later and stays high.
   - pll_reset high for exactly 4 cycles.
   - sys_rst_n and locked rise 2+1+8+1=12 cycles after the pll_lock edge.
   - Sel outputs = INIT_*.
2. pll_lock never rises.
   - Two timeouts of 20 cycles each, retry_cnt 1 then 2.
   - error=1, pll_reset=1, sys_rst_n=0, req_ready=1.
3. In RUN, pulse req_valid with codes 6'd50/6'd40/6'd48.
   - Accepted in 1 cycle, sys_rst_n=0 on the same edge, pll_reset high 4 cycles, sel outputs = 50/40/48 from HOLD entry.
   - After relock, RUN is reached again.
4. pll_lock glitches low for 1 cycle during STABLE.
   - Goes to FAIL, retry_cnt=1, re-HOLD.
   - sys_rst_n never pulses high.
5. In RUN, pll_lock drops.
   - sys_rst_n=0 within 3 cycles, HOLD re-entered, retry_cnt stays 0, codes unchanged.
6. Assert reset_n mid-STABLE after a request for 50/40/48.
   - Outputs return to reset values immediately; sel outputs revert to INIT_*.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - Gowin rPLL supervisor: reset/lock sequencing, retry and dynamic divider reconfiguration
module pll_reconfig_ctrl #(
    parameter logic [5:0] INIT_IDSEL    = 6'd56,
    parameter logic [5:0] INIT_FBDSEL   = 6'd61,
    parameter logic [5:0] INIT_ODSEL    = 6'd32,
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         MAX_RETRY     = 3,
    parameter int         CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idsel,
    input  logic [5:0] req_fbdsel,
    input  logic [5:0] req_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       error,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK->STABLE edge already consumes one qualified sample, so
    // STABLE runs one extra count to give the documented release latency.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             lock_meta, lock_s;
    logic             accept;

    logic             pll_reset_d, sys_rst_n_d, locked_d, error_d, req_ready_d;
    logic [5:0]       pll_idsel_d, pll_fbdsel_d, pll_odsel_d;
    logic [3:0]       retry_cnt_d;

    // req_ready is registered from the next state, so it is high exactly in RUN/ERROR
    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_HOLD;
            cnt        <= '0;
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            pll_reset  <= 1'b1;
            pll_idsel  <= INIT_IDSEL;
            pll_fbdsel <= INIT_FBDSEL;
            pll_odsel  <= INIT_ODSEL;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            retry_cnt  <= 4'd0;
            req_ready  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            lock_meta  <= pll_lock;
            lock_s     <= lock_meta;
            pll_reset  <= pll_reset_d;
            pll_idsel  <= pll_idsel_d;
            pll_fbdsel <= pll_fbdsel_d;
            pll_odsel  <= pll_odsel_d;
            sys_rst_n  <= sys_rst_n_d;
            locked     <= locked_d;
            error      <= error_d;
            retry_cnt  <= retry_cnt_d;
            req_ready  <= req_ready_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_HOLD: begin
                if (cnt == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_d = S_FAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_FAIL;
                    cnt_d   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (accept || !lock_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_FAIL: begin
                state_d = (retry_cnt < RETRY_LIMIT) ? S_HOLD : S_ERROR;
                cnt_d   = '0;
            end
            S_ERROR: begin
                if (accept) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pll_reset_d  = !(state_d == S_WAIT_LOCK || state_d == S_STABLE || state_d == S_RUN);
        sys_rst_n_d  = (state_d == S_RUN);
        locked_d     = (state_d == S_RUN);
        req_ready_d  = (state_d == S_RUN) || (state_d == S_ERROR);
        pll_idsel_d  = pll_idsel;
        pll_fbdsel_d = pll_fbdsel;
        pll_odsel_d  = pll_odsel;
        error_d      = error;
        retry_cnt_d  = retry_cnt;
        if (accept) begin
            pll_idsel_d  = req_idsel;
            pll_fbdsel_d = req_fbdsel;
            pll_odsel_d  = req_odsel;
            error_d      = 1'b0;
            retry_cnt_d  = 4'd0;
        end else if (state_d == S_ERROR) begin
            error_d = 1'b1;
        end else if (state_d == S_RUN) begin
            retry_cnt_d = 4'd0;
        end else if (state_d == S_FAIL) begin
            retry_cnt_d = retry_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - self-checking bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;

    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int ST  = 8;
    localparam int MR  = 2;
    localparam int MAX_DELAY = TO - 4;
    localparam logic [5:0] I_ID = 6'd56;
    localparam logic [5:0] I_FB = 6'd61;
    localparam logic [5:0] I_OD = 6'd32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_idsel, req_fbdsel, req_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       sys_rst_n;
    logic       locked;
    logic       error;
    logic [3:0] retry_cnt;

    int errors = 0;
    int checks = 0;
    logic [5:0] cur_id, cur_fb, cur_od;

    typedef struct {
        logic [5:0] id;
        logic [5:0] fb;
        logic [5:0] od;
        int         nfail;
        int         delay;
        bit         exp_locked;
        bit         exp_error;
        int         exp_retry;
    } vec_t;

    vec_t tbl[6];

    pll_reconfig_ctrl #(
        .INIT_IDSEL   (I_ID),
        .INIT_FBDSEL  (I_FB),
        .INIT_ODSEL   (I_OD),
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRY    (MR),
        .CNT_W        (20)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idsel (req_idsel),
        .req_fbdsel(req_fbdsel),
        .req_odsel (req_odsel),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .error     (error),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sel();
        chk("pll_idsel", pll_idsel, cur_id);
        chk("pll_fbdsel", pll_fbdsel, cur_fb);
        chk("pll_odsel", pll_odsel, cur_od);
    endtask

    task automatic check_reset_values();
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        chk("rst_retry_cnt", retry_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        check_sel();
    endtask

    task automatic check_final(input bit exp_locked, input bit exp_error, input int exp_retry);
        chk("locked", locked, exp_locked);
        chk("sys_rst_n", sys_rst_n, exp_locked);
        chk("error", error, exp_error);
        chk("retry_cnt", retry_cnt, exp_retry);
        chk("pll_reset", pll_reset, !exp_locked);
        chk("req_ready", req_ready, 1);
        check_sel();
    endtask

    task automatic wait_reset_fall(output int n);
        n = 0;
        while (pll_reset !== 1'b0 && n < 100) begin
            step();
            n++;
        end
    endtask

    // Acts as the PLL: nfail attempts never lock, then lock rises delay cycles after RESET falls
    task automatic bring_up(input int nfail, input int delay, input bit chk_hold);
        int n;
        for (int a = 0; a < nfail; a++) begin
            wait_reset_fall(n);
            if (a == 0 && chk_hold) chk("hold_cycles", n, RST);
            chk("pll_reset_fall", pll_reset, 0);
            n = 0;
            while (int'(retry_cnt) != a + 1 && n < 200) begin
                step();
                n++;
            end
            chk("lock_timeout", n, TO);
            chk("sys_rst_n_in_fail", sys_rst_n, 0);
            step();
            if (error === 1'b1) break;
        end
        if (error !== 1'b1) begin
            wait_reset_fall(n);
            if (nfail == 0 && chk_hold) chk("hold_cycles", n, RST);
            chk("pll_reset_fall", pll_reset, 0);
            repeat (delay) step();
            pll_lock = 1'b1;
            n = 0;
            while (sys_rst_n !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            chk("release_latency", n, ST + 4);
        end
    endtask

    task automatic request(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
        chk("req_ready_idle", req_ready, 1);
        req_idsel  = id;
        req_fbdsel = fb;
        req_odsel  = od;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        pll_lock  = 1'b0;
        cur_id = id;
        cur_fb = fb;
        cur_od = od;
        chk("acc_sys_rst_n", sys_rst_n, 0);
        chk("acc_locked", locked, 0);
        chk("acc_pll_reset", pll_reset, 1);
        chk("acc_error", error, 0);
        chk("acc_retry_cnt", retry_cnt, 0);
        chk("acc_req_ready", req_ready, 0);
        check_sel();
    endtask

    function automatic void predict(input int nfail, output bit exp_err, output int exp_retry);
        exp_err   = (nfail >= MR);
        exp_retry = exp_err ? MR : 0;
    endfunction

    initial begin
        int  n;
        bit  saw_high;
        bit  e_err;
        int  e_retry;
        logic [5:0] rid, rfb, rod;
        int  rnf, rdl;

        tbl[0] = '{6'd50, 6'd40, 6'd48, 0, 3,  1'b1, 1'b0, 0};
        tbl[1] = '{6'd12, 6'd34, 6'd56, 1, 5,  1'b1, 1'b0, 0};
        tbl[2] = '{6'd63, 6'd0,  6'd1,  2, 0,  1'b0, 1'b1, 2};
        tbl[3] = '{6'd1,  6'd2,  6'd3,  0, 16, 1'b1, 1'b0, 0};
        tbl[4] = '{6'd7,  6'd7,  6'd7,  3, 0,  1'b0, 1'b1, 2};
        tbl[5] = '{6'd20, 6'd21, 6'd22, 1, 0,  1'b1, 1'b0, 0};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_idsel  = '0;
        req_fbdsel = '0;
        req_odsel  = '0;
        pll_lock   = 1'b0;
        cur_id = I_ID;
        cur_fb = I_FB;
        cur_od = I_OD;

        // Power-up: lock comes 10 cycles after reset release
        repeat (3) step();
        check_reset_values();
        reset_n = 1'b1;
        bring_up(0, 6, 1'b1);
        check_final(1'b1, 1'b0, 0);

        // Loss of lock in RUN
        pll_lock = 1'b0;
        n = 0;
        while (sys_rst_n !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk("loss_within_3", (n >= 1 && n <= 3), 1);
        chk("loss_locked", locked, 0);
        chk("loss_pll_reset", pll_reset, 1);
        chk("loss_retry_cnt", retry_cnt, 0);
        check_sel();
        bring_up(0, 4, 1'b1);
        check_final(1'b1, 1'b0, 0);

        // Reconfiguration request from RUN
        request(6'd50, 6'd40, 6'd48);
        bring_up(0, 2, 1'b1);
        check_final(1'b1, 1'b0, 0);

        // Lock glitch during STABLE, plus a request ignored while busy
        request(6'd9, 6'd10, 6'd11);
        wait_reset_fall(n);
        req_idsel  = 6'd1;
        req_fbdsel = 6'd2;
        req_odsel  = 6'd3;
        req_valid  = 1'b1;
        chk("busy_req_ready", req_ready, 0);
        step();
        req_valid = 1'b0;
        check_sel();
        pll_lock = 1'b1;
        repeat (5) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        n = 0;
        saw_high = 1'b0;
        while (retry_cnt !== 4'd1 && n < 20) begin
            step();
            n++;
            if (sys_rst_n !== 1'b0) saw_high = 1'b1;
        end
        chk("glitch_retry_cnt", retry_cnt, 1);
        chk("glitch_no_release", saw_high, 0);
        pll_lock = 1'b0;
        step();
        chk("glitch_rehold", pll_reset, 1);
        chk("glitch_retry_hold", retry_cnt, 1);
        bring_up(0, 2, 1'b0);
        check_final(1'b1, 1'b0, 0);

        // Request accepted in the cycle synchronised lock falls: request wins
        pll_lock = 1'b0;
        step();
        step();
        request(6'd33, 6'd44, 6'd55);
        bring_up(0, 1, 1'b1);
        check_final(1'b1, 1'b0, 0);

        // Lock never rises after a fresh reset
        reset_n = 1'b0;
        pll_lock = 1'b0;
        cur_id = I_ID;
        cur_fb = I_FB;
        cur_od = I_OD;
        step();
        reset_n = 1'b1;
        bring_up(MR, 0, 1'b1);
        check_final(1'b0, 1'b1, MR);

        for (int i = 0; i < 6; i++) begin
            request(tbl[i].id, tbl[i].fb, tbl[i].od);
            bring_up(tbl[i].nfail, tbl[i].delay, 1'b1);
            check_final(tbl[i].exp_locked, tbl[i].exp_error, tbl[i].exp_retry);
        end

        for (int i = 0; i < 10; i++) begin
            rid = 6'($urandom);
            rfb = 6'($urandom);
            rod = 6'($urandom);
            rnf = int'($urandom_range(0, 3));
            rdl = int'($urandom_range(0, MAX_DELAY));
            predict(rnf, e_err, e_retry);
            request(rid, rfb, rod);
            bring_up(rnf, rdl, 1'b1);
            check_final(!e_err, e_err, e_retry);
        end

        // Async reset mid-STABLE discards the requested codes
        request(6'd50, 6'd40, 6'd48);
        wait_reset_fall(n);
        pll_lock = 1'b1;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        cur_id = I_ID;
        cur_fb = I_FB;
        cur_od = I_OD;
        check_reset_values();
        pll_lock = 1'b0;
        step();
        reset_n = 1'b1;
        bring_up(0, 3, 1'b1);
        check_final(1'b1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
